// File: rtl/reaction_timer_param_if.sv
// rtl/reaction_timer_param_if.sv - trigger inputs and display/status outputs of the reaction timer
interface reaction_timer_param_if #(
    parameter int DIGITS = 4,
    parameter int SEL_W  = 2
);
    logic                start_trigger;
    logic                user_trigger;
    logic                show_best;
    logic [3:0]          ms;
    logic [SEL_W-1:0]    display_select;
    logic                react;
    logic                false_start;
    logic                timeout;
    logic                best_valid;
    logic [4*DIGITS-1:0] result_bcd;

    modport master (
        output start_trigger, user_trigger, show_best,
        input  ms, display_select, react, false_start, timeout, best_valid, result_bcd
    );

    modport slave (
        input  start_trigger, user_trigger, show_best,
        output ms, display_select, react, false_start, timeout, best_valid, result_bcd
    );
endinterface

// File: rtl/reaction_timer_param.sv
// rtl/reaction_timer_param.sv - reaction-time benchmark with BCD ms counter, best-time tracking and digit scan
module reaction_timer_param #(
    parameter int          CLKS_PER_MS     = 50,
    parameter int          DIGITS          = 4,
    parameter int          SEL_W           = 2,
    parameter int          DELAY_MIN_MS    = 1000,
    parameter int          DELAY_RAND_BITS = 12,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    reaction_timer_param_if.slave bus
);
    localparam int                  PRE_W     = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [4*DIGITS-1:0] NINES     = {DIGITS{4'h9}};
    localparam logic [31:0]         RAND_MASK = (32'd1 << DELAY_RAND_BITS) - 32'd1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REACT, S_SHOW, S_FAULT} state_t;

    state_t              r_state;
    logic [15:0]         r_lfsr;
    logic [PRE_W-1:0]    r_presc;
    logic [31:0]         r_delay;
    logic [4*DIGITS-1:0] r_result;
    logic [4*DIGITS-1:0] r_best;
    logic                r_best_valid;
    logic                r_react;
    logic                r_false;
    logic                r_timeout;
    logic [SEL_W-1:0]    r_sel;
    logic [3:0]          r_ms;

    logic                w_tick;
    logic                w_wait_entry;
    logic                w_inc;
    logic                w_reach_max;
    logic                w_best_upd;
    logic                w_carry;
    logic [31:0]         w_delay_load;
    logic [4*DIGITS-1:0] w_result_inc;
    logic [4*DIGITS-1:0] w_result_nxt;
    logic [4*DIGITS-1:0] w_best_nxt;
    logic [4*DIGITS-1:0] w_src;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic [3:0]          w_ms_nxt;

    assign w_tick       = (r_presc == PRE_W'(CLKS_PER_MS - 1));
    assign w_wait_entry = bus.start_trigger &&
                          (r_state == S_IDLE || r_state == S_SHOW || r_state == S_FAULT);
    assign w_delay_load = 32'(DELAY_MIN_MS) + ({16'd0, r_lfsr} & RAND_MASK);
    assign w_inc        = (r_state == S_REACT) && !bus.user_trigger && w_tick;
    assign w_reach_max  = w_inc && (w_result_inc == NINES);
    assign w_best_upd   = (r_state == S_REACT) && bus.user_trigger &&
                          (!r_best_valid || (r_result < r_best));

    // Decimal ripple increment: a digit only advances while every lower digit wraps 9 -> 0.
    always_comb begin
        w_carry      = 1'b1;
        w_result_inc = r_result;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_result[4*i +: 4] == 4'd9) begin
                    w_result_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_result_inc[4*i +: 4] = r_result[4*i +: 4] + 4'd1;
                    w_carry                = 1'b0;
                end
            end
        end
    end

    assign w_result_nxt = w_wait_entry ? '0 : (w_inc ? w_result_inc : r_result);
    assign w_best_nxt   = w_best_upd ? r_result : r_best;

    always_comb begin
        w_sel_nxt = '0;
        if (!w_wait_entry && (r_sel != SEL_W'(DIGITS - 1))) begin
            w_sel_nxt = r_sel + SEL_W'(1);
        end
    end

    // The scan digit comes from next-cycle values so ms never lags display_select or a count.
    assign w_src = bus.show_best ? w_best_nxt : w_result_nxt;

    always_comb begin
        w_ms_nxt = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_sel_nxt == SEL_W'(i)) begin
                w_ms_nxt = w_src[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_presc      <= '0;
            r_delay      <= '0;
            r_result     <= '0;
            r_best       <= NINES;
            r_best_valid <= 1'b0;
            r_react      <= 1'b0;
            r_false      <= 1'b0;
            r_timeout    <= 1'b0;
            r_sel        <= '0;
            r_ms         <= 4'd0;
        end else begin
            r_lfsr   <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            r_presc  <= w_tick ? '0 : r_presc + PRE_W'(1);
            r_result <= w_result_nxt;
            r_best   <= w_best_nxt;
            r_sel    <= w_sel_nxt;
            r_ms     <= w_ms_nxt;

            if (w_wait_entry) begin
                r_state   <= S_WAIT;
                r_presc   <= '0;
                r_delay   <= w_delay_load;
                r_timeout <= 1'b0;
                r_false   <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (bus.user_trigger) begin
                            r_state <= S_FAULT;
                            r_false <= 1'b1;
                        end else if (w_tick) begin
                            r_delay <= r_delay - 32'd1;
                            if (r_delay == 32'd1) begin
                                r_state <= S_REACT;
                                r_presc <= '0;
                            end
                        end
                    end
                    S_REACT: begin
                        if (bus.user_trigger) begin
                            r_state <= S_SHOW;
                            r_react <= 1'b0;
                            if (w_best_upd) begin
                                r_best_valid <= 1'b1;
                            end
                        end else if (w_reach_max) begin
                            r_state   <= S_SHOW;
                            r_react   <= 1'b0;
                            r_timeout <= 1'b1;
                        end else begin
                            r_react <= 1'b1;
                        end
                    end
                    default: begin
                        r_react <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ms             = r_ms;
    assign bus.display_select = r_sel;
    assign bus.react          = r_react;
    assign bus.false_start    = r_false;
    assign bus.timeout        = r_timeout;
    assign bus.best_valid     = r_best_valid;
    assign bus.result_bcd     = r_result;
endmodule
